// File: rtl/pulse_hs_pkg.sv
// Shared definitions for the toggle-based pulse handshake (transmitter and
// its matching receiver): state encoding and default parameter values.
package pulse_hs_pkg;

  // Transmitter handshake states.
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  // Default pending-event counter width; max queued = 2^CNT_W-1.
  localparam int DEF_CNT_W       = 4;
  // Default flop count in the ack synchronizer (must be >= 2).
  localparam int DEF_SYNC_STAGES = 2;
  // Default WAIT_ACK cycle budget before the timeout flag is raised.
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with synchronous active-high reset.
// Shared by the pulse handshake transmitter and receiver.
module sync_bit
  import pulse_hs_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    // NOTE: reset is tested inside the clocked branch, so it is synchronous;
    // the chain is cleared like any other register, not left uninitialised.
    if (rst) begin
      r_chain <= '0;
    end else begin
      // NOTE: non-blocking assignment lets each stage capture the previous
      // stage's old value; blocking would collapse the chain into one flop.
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Source-side transmitter for a toggle-based pulse crossing.
// Single-cycle pulses are queued in a saturating pending counter and
// launched one at a time by flipping req_toggle; the next launch waits for
// the receiver to echo req_toggle back on ack_toggle.
// Optional feature macro: PULSE_TX_TIMEOUT_EN adds a sticky timeout_err
// output raised after TIMEOUT_CYC cycles spent waiting for the ack.
module pulse_handshake_tx
  import pulse_hs_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_toggle,
  output logic             req_toggle,
  output logic             busy,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow
`ifdef PULSE_TX_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  // Legacy-style state encodings, tied to the shared enum values.
  localparam logic [0:0] S_IDLE     = ST_IDLE;
  localparam logic [0:0] S_WAIT_ACK = ST_WAIT_ACK;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject parameter values the handshake cannot work with.
  if (SYNC_STAGES < 2 || CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("pulse_handshake_tx: illegal parameter value");
  end

  logic [0:0]       r_state;
  logic             r_req_toggle;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overflow;

  logic w_ack_s;
  logic w_ack_match;
  logic w_idle;
  logic w_cnt_zero;
  logic w_cnt_full;
  logic w_launch;
  logic w_inc;
  logic w_dec;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ack_toggle),
    .o_q (w_ack_s)
  );

  assign w_ack_match = (w_ack_s == r_req_toggle);
  assign w_idle      = (r_state == S_IDLE);
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_cnt_full  = (r_cnt == CNT_MAX);

  // Launch only from IDLE, so nothing launches on the WAIT_ACK exit edge.
  assign w_launch = w_idle && (pulse_in || !w_cnt_zero);
  // A launch from an empty queue consumes pulse_in directly: it is neither
  // counted in nor counted out.
  assign w_dec    = w_launch && !w_cnt_zero;
  assign w_inc    = pulse_in && !(w_launch && w_cnt_zero);

  // Handshake FSM: flip req_toggle on launch, return to IDLE once the
  // synchronized ack matches. Ack changes seen in IDLE are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_toggle <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_req_toggle <= ~r_req_toggle;
            r_state      <= S_WAIT_ACK;
          end
        end
        default: begin
          if (w_ack_match) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Saturating pending counter; a pulse arriving while full is dropped and
  // flagged with a one-cycle overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_inc && !w_dec) begin
        if (w_cnt_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

`ifdef PULSE_TX_TIMEOUT_EN
  localparam int              TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  // Count WAIT_ACK cycles (cleared while IDLE, so it starts at 0 on entry);
  // raise a sticky flag on the edge the count reaches TIMEOUT_CYC. The FSM
  // is left alone so a late ack still completes the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_idle) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LIMIT) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end
      if (!w_idle && r_to_cnt == TO_LAST) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  assign req_toggle  = r_req_toggle;
  assign busy        = (r_state == S_WAIT_ACK);
  assign pending_cnt = r_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Testbench for pulse_handshake_tx. Two instances share clk/rst:
//   A: CNT_W=4 (single event, burst, simultaneous inc/dec, stray ack)
//   B: CNT_W=2, TIMEOUT_CYC=16 (overflow, optional timeout)
// Each instance has an echo process acting as the receiver and a monitor
// that scores every req_toggle flip and overflow pulse against a queue of
// hand-computed expectations pushed by the stimulus.
module tb_pulse_handshake_tx;

  typedef struct {
    bit is_ovf;   // 0: req_toggle flip, 1: overflow pulse
    int cnt;      // pending_cnt seen in the cycle the event appears
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       pulse_a = 1'b0, ack_a = 1'b0;
  logic       req_a, busy_a, ovf_a;
  logic [3:0] cnt_a;

  logic       pulse_b = 1'b0, ack_b = 1'b0;
  logic       req_b, busy_b, ovf_b;
  logic [1:0] cnt_b;
`ifdef PULSE_TX_TIMEOUT_EN
  logic       to_a, to_b;
`endif

  bit echo_en_a = 1'b1;
  bit echo_en_b = 1'b1;

  ev_t exp_a[$];
  ev_t exp_b[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pulse_handshake_tx #(
    .CNT_W (4), .SYNC_STAGES (2), .TIMEOUT_CYC (1024)
  ) u_dut_a (
    .clk (clk), .rst (rst), .pulse_in (pulse_a), .ack_toggle (ack_a),
    .req_toggle (req_a), .busy (busy_a), .pending_cnt (cnt_a),
    .overflow (ovf_a)
`ifdef PULSE_TX_TIMEOUT_EN
    , .timeout_err (to_a)
`endif
  );

  pulse_handshake_tx #(
    .CNT_W (2), .SYNC_STAGES (2), .TIMEOUT_CYC (16)
  ) u_dut_b (
    .clk (clk), .rst (rst), .pulse_in (pulse_b), .ack_toggle (ack_b),
    .req_toggle (req_b), .busy (busy_b), .pending_cnt (cnt_b),
    .overflow (ovf_b)
`ifdef PULSE_TX_TIMEOUT_EN
    , .timeout_err (to_b)
`endif
  );

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic score(input string tag, input bit is_ovf, input int cnt,
                       input bit have, input ev_t e);
    if (!have) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: unexpected event ovf=%0d cnt=%0d, none expected",
               tag, is_ovf, cnt);
    end else begin
      check({tag, ".kind"}, int'(is_ovf), int'(e.is_ovf));
      check({tag, ".cnt"}, cnt, e.cnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Receiver model: echo req_toggle on ack_toggle so that ack changes just
  // before the 4th edge after the flip (unless the echo is held off).
  initial forever begin
    @(req_a);
    repeat (3) @(posedge clk);
    #1;
    if (echo_en_a) ack_a = req_a;
  end

  initial forever begin
    @(req_b);
    repeat (3) @(posedge clk);
    #1;
    if (echo_en_b) ack_b = req_b;
  end

  // Monitors: score every flip and overflow pulse, sampled on the falling edge.
  logic prev_req_a = 1'b0;
  logic prev_req_b = 1'b0;
  ev_t  ev_none = '{is_ovf: 1'b0, cnt: 0};

  always @(negedge clk) begin
    if (rst) begin
      prev_req_a = 1'b0;
    end else begin
      if (req_a !== prev_req_a) begin
        prev_req_a = req_a;
        if (exp_a.size() > 0) score("A.flip", 1'b0, int'(cnt_a), 1'b1, exp_a.pop_front());
        else                  score("A.flip", 1'b0, int'(cnt_a), 1'b0, ev_none);
      end
      if (ovf_a) begin
        if (exp_a.size() > 0) score("A.ovf", 1'b1, int'(cnt_a), 1'b1, exp_a.pop_front());
        else                  score("A.ovf", 1'b1, int'(cnt_a), 1'b0, ev_none);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_req_b = 1'b0;
    end else begin
      if (req_b !== prev_req_b) begin
        prev_req_b = req_b;
        if (exp_b.size() > 0) score("B.flip", 1'b0, int'(cnt_b), 1'b1, exp_b.pop_front());
        else                  score("B.flip", 1'b0, int'(cnt_b), 1'b0, ev_none);
      end
      if (ovf_b) begin
        if (exp_b.size() > 0) score("B.ovf", 1'b1, int'(cnt_b), 1'b1, exp_b.pop_front());
        else                  score("B.ovf", 1'b1, int'(cnt_b), 1'b0, ev_none);
      end
    end
  end

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Reset with random activity on the inputs ----
    for (int i = 0; i < 2; i++) begin
      pulse_a = 1'($urandom_range(0, 1));
      ack_a   = 1'($urandom_range(0, 1));
      pulse_b = 1'($urandom_range(0, 1));
      ack_b   = 1'($urandom_range(0, 1));
      tick(1);
    end
    rst = 1'b0; pulse_a = 1'b0; ack_a = 1'b0; pulse_b = 1'b0; ack_b = 1'b0;
    @(negedge clk);
    check("rst.req_a", int'(req_a), 0);
    check("rst.busy_a", int'(busy_a), 0);
    check("rst.cnt_a", int'(cnt_a), 0);
    check("rst.ovf_a", int'(ovf_a), 0);
    check("rst.req_b", int'(req_b), 0);
    check("rst.busy_b", int'(busy_b), 0);
    check("rst.cnt_b", int'(cnt_b), 0);
`ifdef PULSE_TX_TIMEOUT_EN
    check("rst.to_b", int'(to_b), 0);
`endif
    tick(2);

    // ---- Single event: launch on next edge, busy drops 3 edges after ack ----
    exp_a.push_back('{is_ovf: 1'b0, cnt: 0});
    pulse_a = 1'b1;
    tick(1);                                   // E1: launch
    pulse_a = 1'b0;
    check("single.req", int'(req_a), 1);
    check("single.busy_on", int'(busy_a), 1);
    check("single.cnt", int'(cnt_a), 0);
    tick(5);                                   // E6: ack_s seen, still busy
    check("single.busy_e6", int'(busy_a), 1);
    tick(1);                                   // E7: back to IDLE
    check("single.busy_off", int'(busy_a), 0);
    tick(2);
    check("single.done", exp_a.size(), 0);

    // ---- Burst of 5: launch, queue 4, drain one per 7-cycle handshake ----
    exp_a.push_back('{is_ovf: 1'b0, cnt: 0});
    exp_a.push_back('{is_ovf: 1'b0, cnt: 3});
    exp_a.push_back('{is_ovf: 1'b0, cnt: 2});
    exp_a.push_back('{is_ovf: 1'b0, cnt: 1});
    exp_a.push_back('{is_ovf: 1'b0, cnt: 0});
    for (int i = 0; i < 5; i++) begin
      pulse_a = 1'b1;
      tick(1);
    end
    pulse_a = 1'b0;
    check("burst.peak", int'(cnt_a), 4);
    check("burst.busy", int'(busy_a), 1);
    tick(35);
    check("burst.final_cnt", int'(cnt_a), 0);
    check("burst.final_busy", int'(busy_a), 0);
    check("burst.flips", exp_a.size(), 0);

    // ---- Simultaneous inc and dec with 2 queued in IDLE ----
    exp_a.push_back('{is_ovf: 1'b0, cnt: 0});
    for (int i = 0; i < 3; i++) begin
      pulse_a = 1'b1;
      tick(1);
    end
    pulse_a = 1'b0;
    check("incdec.queued", int'(cnt_a), 2);
    tick(3);
    check("incdec.busy_p6", int'(busy_a), 1);
    tick(1);
    check("incdec.idle", int'(busy_a), 0);
    check("incdec.cnt_idle", int'(cnt_a), 2);
    exp_a.push_back('{is_ovf: 1'b0, cnt: 2});
    pulse_a = 1'b1;
    tick(1);
    pulse_a = 1'b0;
    check("incdec.cnt_kept", int'(cnt_a), 2);
    check("incdec.busy", int'(busy_a), 1);
    exp_a.push_back('{is_ovf: 1'b0, cnt: 1});
    exp_a.push_back('{is_ovf: 1'b0, cnt: 0});
    tick(22);
    check("incdec.final_cnt", int'(cnt_a), 0);
    check("incdec.final_busy", int'(busy_a), 0);
    check("incdec.flips", exp_a.size(), 0);

    // Stray ack flip while IDLE: ignored (10 flips so far, req_a is 0).
    ack_a = ~ack_a;
    tick(6);
    check("stray.busy", int'(busy_a), 0);
    check("stray.req", int'(req_a), 0);
    check("stray.cnt", int'(cnt_a), 0);

    // ---- Overflow with CNT_W=2 and ack held ----
    echo_en_b = 1'b0;
    exp_b.push_back('{is_ovf: 1'b0, cnt: 0});
    exp_b.push_back('{is_ovf: 1'b1, cnt: 3});
    exp_b.push_back('{is_ovf: 1'b1, cnt: 3});
    for (int i = 0; i < 6; i++) begin
      pulse_b = 1'b1;
      tick(1);
    end
    pulse_b = 1'b0;
    check("ovf.sat_cnt", int'(cnt_b), 3);
    check("ovf.pulse_5th", int'(ovf_b), 1);
    check("ovf.busy", int'(busy_b), 1);
    ack_b = req_b;
    echo_en_b = 1'b1;
    exp_b.push_back('{is_ovf: 1'b0, cnt: 2});
    exp_b.push_back('{is_ovf: 1'b0, cnt: 1});
    exp_b.push_back('{is_ovf: 1'b0, cnt: 0});
    tick(2);
    check("ovf.busy_hold", int'(busy_b), 1);
    check("ovf.pulse_clear", int'(ovf_b), 0);
    tick(1);
    check("ovf.idle", int'(busy_b), 0);
    check("ovf.idle_cnt", int'(cnt_b), 3);
    tick(1);
    check("ovf.relaunch_busy", int'(busy_b), 1);
    check("ovf.relaunch_cnt", int'(cnt_b), 2);
    tick(25);
    check("ovf.final_cnt", int'(cnt_b), 0);
    check("ovf.final_busy", int'(busy_b), 0);
    check("ovf.flips", exp_b.size(), 0);

`ifdef PULSE_TX_TIMEOUT_EN
    // ---- Timeout: flag on the 16th WAIT_ACK edge, late ack still recovers ----
    check("to.before", int'(to_b), 0);
    echo_en_b = 1'b0;
    exp_b.push_back('{is_ovf: 1'b0, cnt: 0});
    pulse_b = 1'b1;
    tick(1);                                   // E0: enter WAIT_ACK
    pulse_b = 1'b0;
    check("to.busy", int'(busy_b), 1);
    tick(15);                                  // E15
    check("to.e15", int'(to_b), 0);
    tick(1);                                   // E16
    check("to.e16", int'(to_b), 1);
    tick(4);
    check("to.sticky", int'(to_b), 1);
    check("to.still_busy", int'(busy_b), 1);
    ack_b = req_b;
    echo_en_b = 1'b1;
    tick(3);
    check("to.recovered", int'(busy_b), 0);
    check("to.sticky_idle", int'(to_b), 1);
    check("to.flips", exp_b.size(), 0);
    check("to.a_clear", int'(to_a), 0);
`endif

    tick(4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_handshake_tx.md
Name: pulse_handshake_tx

Overview:
- Source-side transmitter for a toggle-based pulse crossing.
- Accepts single-cycle event pulses in its own clock domain and queues them as a pending count.
- Launches one event at a time by flipping `req_toggle`, then waits until the far-side receiver echoes it back on `ack_toggle`.
- Unlike a bare toggle synchronizer, back-to-back pulses are never lost while the count has room.

Parameters:
- CNT_W, 4, width of pending-event counter; max queued = 2^CNT_W-1
- SYNC_STAGES, 2, flops in the `ack_toggle` synchronizer chain (legal >= 2)
- TIMEOUT_CYC, 1024, WAIT_ACK cycles before `timeout_err` (used only with the optional feature)

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- pulse_in  input  1  event strobe; each high cycle is one event
- ack_toggle  input  1  echo of `req_toggle` from the receiver domain; asynchronous to `clk`
- req_toggle  output  1  registered; flips once per launched event
- busy  output  1  high while in WAIT_ACK
- pending_cnt  output  CNT_W  events queued, not yet launched
- overflow  output  1  one-cycle pulse when an event is dropped
- timeout_err  output  1  sticky; present only with PULSE_TX_TIMEOUT_EN

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port `clk`, reset port `rst`.
- Reset, sampled on a `clk` edge, clears all outputs and state:
  - `req_toggle`=0, `busy`=0, `pending_cnt`=0, `overflow`=0, `timeout_err`=0
  - ack synchronizer flops = 0; state = IDLE
- Reset mid-operation discards queued and in-flight events. The receiver must be reset concurrently; this is a system requirement, not checked here.
- Ack synchronizer: `ack_toggle` passes through SYNC_STAGES flops, giving `ack_s`. Only the last stage is used. `ack_match` = (`ack_s` == `req_toggle`).
- State machine has two states: IDLE and WAIT_ACK.
  - IDLE, launch condition = (`pending_cnt`!=0) OR `pulse_in`. On launch: `req_toggle` flips at the next edge and state becomes WAIT_ACK.
  - WAIT_ACK: go to IDLE on the edge where `ack_match`=1. The `ack_match` term is the combinational compare of `ack_s` and `req_toggle`.
  - No launch is allowed in the same cycle WAIT_ACK exits. The earliest next launch is from IDLE one cycle later.
- Latency:
  - `pulse_in` in IDLE with an empty queue: `req_toggle` flips at the next edge.
  - `ack_toggle` change to `busy` deassert: SYNC_STAGES+1 edges.
- Counter update per edge:
  - inc = `pulse_in`; dec = launch AND (`pending_cnt`!=0)
  - A launch from an empty count consumes `pulse_in` directly, so neither inc nor dec applies.
  - inc and dec together: count unchanged.
  - inc only, count < max: count+1.
  - inc only, count == max: count stays at max and `overflow`=1 for one cycle. The event is lost.
  - dec only: count-1. The counter never wraps.
- `busy` is a decode of the state register, so it is glitch-free.
- An `ack_toggle` transition while IDLE is a protocol error. It is ignored: `ack_match` is only evaluated in WAIT_ACK.

Optional Feature:
- Macro: PULSE_TX_TIMEOUT_EN
- Defined:
  - A cycle counter resets on entry to WAIT_ACK and increments while in WAIT_ACK.
  - When it reaches TIMEOUT_CYC, `timeout_err` is set and stays high until `rst`.
  - State is not changed, so the handshake remains recoverable if the ack arrives late.
- Undefined: no timeout counter and no `timeout_err` port.

Decomposition:
- Package `pulse_hs_pkg` holds:
  - the state enum (IDLE, WAIT_ACK)
  - default constants for CNT_W, SYNC_STAGES, TIMEOUT_CYC
- One sub-module: `sync_bit`, a parameterised N-stage single-bit synchronizer with synchronous reset. It is reused by the matching receiver block.

Test Plan:
1. Reset: hold `rst`=1 for 2 cycles while `ack_toggle` and `pulse_in` are driven randomly -> `req_toggle`=0, `busy`=0, `pending_cnt`=0, `overflow`=0 on the first cycle after release.
2. Single event (bench echoes `req_toggle` to `ack_toggle` after 4 cycles):
   - `pulse_in`=1 at cycle 5 -> `req_toggle` 0->1 and `busy`=1 at edge 6, `pending_cnt` stays 0.
   - `ack_toggle` rises before edge 10 -> `busy`=0 after edge 12 (SYNC_STAGES=2).
3. Burst of 5 consecutive pulses, ack echoed after 4 cycles -> `pending_cnt` peaks at 4; exactly 5 `req_toggle` flips; final `pending_cnt`=0; `overflow` never asserted.
4. Overflow with CNT_W=2 and ack held: 5 pulses while busy -> `pending_cnt` saturates at 3; `overflow` pulses on the 4th and 5th; after releasing ack, exactly 3 more flips occur.
5. Simultaneous inc and dec: `pending_cnt`=2 in IDLE with `pulse_in`=1 -> launch occurs and `pending_cnt` stays 2; spurious `ack_toggle` flip while IDLE -> no state change.
6. PULSE_TX_TIMEOUT_EN with TIMEOUT_CYC=16, ack withheld -> `timeout_err`=1 at the 16th WAIT_ACK cycle and stays high; a late ack then returns `busy` to 0.
